ifetch_unit: RTL and testbench

- Consumer side of the program counter: owns the fetch PC, issues instruction-memory read requests over a valid/ready channel, and accepts in-order responses.
- Buffers fetched words with their PCs in a small FIFO and presents them to decode over a valid/ready channel.
- Redirects from branch/jump resolution flush the buffer and discard in-flight responses.

---
 rtl/ifetch_unit_if.sv | 36 +++
 rtl/ifetch_unit.sv | 118 +++++++++++
 tb/tb_ifetch_unit.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_unit_if.sv
// Handshake bundle between the fetch unit, instruction memory and decode.
// slave = fetch unit side, master = memory/decode/branch-resolution side.
interface ifetch_unit_if;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;

   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;

   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr_data;
   logic [31:0] instr_pc;

   modport slave (
      input  redirect_valid, redirect_pc,
      output imem_req_valid, imem_req_addr,
      input  imem_req_ready,
      input  imem_rsp_valid, imem_rsp_data,
      output instr_valid, instr_data, instr_pc,
      input  instr_ready
   );

   modport master (
      output redirect_valid, redirect_pc,
      input  imem_req_valid, imem_req_addr,
      output imem_req_ready,
      output imem_rsp_valid, imem_rsp_data,
      input  instr_valid, instr_data, instr_pc,
      output instr_ready
   );
endinterface

// File: rtl/ifetch_unit.sv
// Fetch PC owner: credit-limited imem requests, in-order responses into a PC-tagged buffer for decode.
// Response visible to decode one cycle after arrival; requests stall when buffer+in-flight reach FIFO_DEPTH.
module ifetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 4,
   parameter logic [31:0] PC_STEP    = 32'd4
) (
   input  logic         clk,
   input  logic         reset,
   ifetch_unit_if.slave bus
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int SUM_W = CNT_W + 1;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] data;
   } entry_t;

   logic [31:0]      fetch_pc_q, fetch_pc_d;
   logic [31:0]      rsp_pc_q, rsp_pc_d;
   logic [CNT_W-1:0] outstanding_q, outstanding_d;
   logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   entry_t           mem_q [FIFO_DEPTH];
   entry_t           mem_d [FIFO_DEPTH];

   logic   credit_ok;
   logic   req_valid;
   logic   req_fire;
   logic   instr_valid;
   logic   pop;
   logic   rsp_drop;
   logic   push;
   entry_t head;

   // Buffered entries plus in-flight requests never exceed the buffer size,
   // so every response is guaranteed a free slot.
   assign credit_ok   = ({1'b0, count_q} + {1'b0, outstanding_q}) < SUM_W'(FIFO_DEPTH);
   assign req_valid   = reset && credit_ok && !bus.redirect_valid;
   assign req_fire    = req_valid && bus.imem_req_ready;
   assign instr_valid = reset && (count_q != '0) && !bus.redirect_valid;
   assign pop         = instr_valid && bus.instr_ready;
   assign rsp_drop    = bus.imem_rsp_valid && (drop_cnt_q != '0);
   assign push        = bus.imem_rsp_valid && (drop_cnt_q == '0) && !bus.redirect_valid;
   assign head        = mem_q[rd_ptr_q];

   assign bus.imem_req_valid = req_valid;
   assign bus.imem_req_addr  = reset ? fetch_pc_q : RESET_PC;
   assign bus.instr_valid    = instr_valid;
   assign bus.instr_data     = reset ? head.data : '0;
   assign bus.instr_pc       = reset ? head.pc   : '0;

   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      rsp_pc_d      = rsp_pc_q;
      drop_cnt_d    = drop_cnt_q;
      count_d       = count_q;
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      mem_d         = mem_q;
      outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(bus.imem_rsp_valid);

      if (bus.redirect_valid) begin
         // Everything still in flight belongs to the old path, including a
         // response landing in this very cycle.
         fetch_pc_d = bus.redirect_pc;
         rsp_pc_d   = bus.redirect_pc;
         drop_cnt_d = outstanding_q - CNT_W'(bus.imem_rsp_valid);
         count_d    = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
      end else begin
         if (req_fire) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
         end
         if (rsp_drop) begin
            drop_cnt_d = drop_cnt_q - CNT_W'(1);
         end
         if (push) begin
            mem_d[wr_ptr_q] = '{pc: rsp_pc_q, data: bus.imem_rsp_data};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            rsp_pc_d        = rsp_pc_q + PC_STEP;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_pc_q    <= RESET_PC;
         rsp_pc_q      <= RESET_PC;
         outstanding_q <= '0;
         drop_cnt_q    <= '0;
         count_q       <= '0;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         rsp_pc_q      <= rsp_pc_d;
         outstanding_q <= outstanding_d;
         drop_cnt_q    <= drop_cnt_d;
         count_q       <= count_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         mem_q         <= mem_d;
      end
   end
endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: randomized memory/decode environment against a request/instruction queue model.
module tb_ifetch_unit;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          DEPTH    = 4;
   localparam logic [31:0] STEP     = 32'd4;
   localparam logic [31:0] XORK     = 32'hA5A5_A5A5;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   ifetch_unit_if bus ();

   ifetch_unit #(
      .RESET_PC  (RESET_PC),
      .FIFO_DEPTH(DEPTH),
      .PC_STEP   (STEP)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   // In-flight request: its address, the cycle its response is due, and
   // whether it still belongs to the current fetch path.
   typedef struct {
      logic [31:0] addr;
      int          due;
      bit          keep;
   } flight_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
   } instr_t;

   flight_t     fl[$];
   instr_t      iq[$];
   logic [31:0] mfetch;
   int          cyc;
   int          last_due;
   int          lat;
   logic [31:0] fire_log[$];
   logic [31:0] pop_log[$];
   logic [31:0] popd_log[$];
   int          passes;
   int          total;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic model_reset();
      fl.delete();
      iq.delete();
      mfetch   = RESET_PC;
      last_due = -1;
   endtask

   task automatic clear_logs();
      fire_log.delete();
      pop_log.delete();
      popd_log.delete();
   endtask

   task automatic drive_idle();
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
      bus.instr_ready    = 1'b0;
   endtask

   task automatic check_reset_outputs(input string where);
      chk({where, "_req_valid"},   bus.imem_req_valid, 32'd0);
      chk({where, "_instr_valid"}, bus.instr_valid,    32'd0);
      chk({where, "_req_addr"},    bus.imem_req_addr,  RESET_PC);
      chk({where, "_instr_data"},  bus.instr_data,     32'd0);
      chk({where, "_instr_pc"},    bus.instr_pc,       32'd0);
   endtask

   // Called at a negedge; returns at the following negedge.
   task automatic step(input bit rdr, input logic [31:0] rpc, input bit rreq, input bit irdy);
      flight_t f;
      bit      rsp, exp_rv, exp_iv, fire, pop;
      int      d;
      bus.redirect_valid = rdr;
      bus.redirect_pc    = rpc;
      bus.imem_req_ready = rreq;
      bus.instr_ready    = irdy;
      rsp = (fl.size() > 0) && (fl[0].due <= cyc);
      bus.imem_rsp_valid = rsp;
      bus.imem_rsp_data  = rsp ? (fl[0].addr ^ XORK) : $urandom();
      #1;
      exp_rv = ((iq.size() + fl.size()) < DEPTH) && !rdr;
      exp_iv = (iq.size() > 0) && !rdr;
      chk("req_valid", bus.imem_req_valid, 32'(exp_rv));
      if (exp_rv) chk("req_addr", bus.imem_req_addr, mfetch);
      chk("instr_valid", bus.instr_valid, 32'(exp_iv));
      if (exp_iv) begin
         chk("instr_pc",   bus.instr_pc,   iq[0].pc);
         chk("instr_data", bus.instr_data, iq[0].data);
      end
      fire = exp_rv && rreq;
      pop  = exp_iv && irdy;
      if (fire) fire_log.push_back(mfetch);
      if (pop) begin
         pop_log.push_back(iq[0].pc);
         popd_log.push_back(iq[0].data);
      end
      @(posedge clk);
      cyc++;
      if (pop) void'(iq.pop_front());
      if (rsp) begin
         f = fl.pop_front();
         if (f.keep && !rdr) iq.push_back('{f.addr, f.addr ^ XORK});
      end
      if (fire) begin
         d = cyc + lat - 1;
         if (d <= last_due) d = last_due + 1;
         last_due = d;
         fl.push_back('{mfetch, d, 1'b1});
         mfetch = mfetch + STEP;
      end
      if (rdr) begin
         foreach (fl[i]) fl[i].keep = 1'b0;
         iq.delete();
         mfetch = rpc;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      drive_idle();
      #1;
      check_reset_outputs("rst");
      repeat (2) @(negedge clk);
      model_reset();
      reset = 1'b1;
   endtask

   initial begin
      passes = 0;
      total  = 0;
      cyc    = 0;
      lat    = 1;
      drive_idle();
      model_reset();
      @(negedge clk);
      do_reset();

      // Streaming with a single-cycle memory.
      clear_logs();
      repeat (12) step(1'b0, '0, 1'b1, 1'b1);
      chk("stream_fire0", fire_log[0], 32'h0);
      chk("stream_fire1", fire_log[1], 32'h4);
      chk("stream_fire2", fire_log[2], 32'h8);
      chk("stream_fire3", fire_log[3], 32'hC);
      chk("stream_pc0",   pop_log[0],  32'h0);
      chk("stream_data0", popd_log[0], 32'hA5A5_A5A5);
      chk("stream_pc1",   pop_log[1],  32'h4);
      chk("stream_data1", popd_log[1], 32'hA5A5_A5A1);
      chk("stream_pops",  32'(pop_log.size()), 32'd10);

      // Decode stalled: the credit limit caps requests at the buffer size.
      do_reset();
      clear_logs();
      repeat (10) step(1'b0, '0, 1'b1, 1'b0);
      chk("stall_fires", 32'(fire_log.size()), 32'd4);
      chk("stall_req_valid", bus.imem_req_valid, 32'd0);
      repeat (8) step(1'b0, '0, 1'b1, 1'b1);
      chk("drain_pc0", pop_log[0], 32'h0);
      chk("drain_pc1", pop_log[1], 32'h4);
      chk("drain_pc2", pop_log[2], 32'h8);
      chk("drain_pc3", pop_log[3], 32'hC);
      chk("resume_addr", fire_log[4], 32'h10);

      // Redirect with three requests outstanding on a 3-cycle memory.
      do_reset();
      clear_logs();
      lat = 3;
      repeat (3) step(1'b0, '0, 1'b1, 1'b1);
      chk("lat3_fires", 32'(fire_log.size()), 32'd3);
      step(1'b1, 32'h100, 1'b1, 1'b1);
      clear_logs();
      repeat (12) step(1'b0, '0, 1'b1, 1'b1);
      chk("redir_first_pc",  pop_log[0],  32'h100);
      chk("redir_first_req", fire_log[0], 32'h100);

      // Redirect coinciding with the only outstanding response.
      do_reset();
      lat = 1;
      step(1'b0, '0, 1'b1, 1'b1);
      step(1'b1, 32'h200, 1'b0, 1'b1);
      clear_logs();
      repeat (8) step(1'b0, '0, 1'b1, 1'b1);
      chk("same_cyc_pc",  pop_log[0],  32'h200);
      chk("same_cyc_req", fire_log[0], 32'h200);

      // Address wrap at the top of the 32-bit space.
      step(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1);
      clear_logs();
      repeat (8) step(1'b0, '0, 1'b1, 1'b1);
      chk("wrap_req0", fire_log[0], 32'hFFFF_FFF8);
      chk("wrap_req1", fire_log[1], 32'hFFFF_FFFC);
      chk("wrap_req2", fire_log[2], 32'h0000_0000);
      chk("wrap_pc0",  pop_log[0],  32'hFFFF_FFF8);
      chk("wrap_pc1",  pop_log[1],  32'hFFFF_FFFC);
      chk("wrap_pc2",  pop_log[2],  32'h0000_0000);

      // Random traffic: latency, both readies and redirects all vary.
      for (int n = 0; n < 400; n++) begin
         if (n % 50 == 0) lat = $urandom_range(1, 3);
         step($urandom_range(0, 19) == 0, $urandom() & 32'hFFFF_FFFC,
              $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
      end

      // Asynchronous reset between edges while streaming.
      lat = 1;
      repeat (6) step(1'b0, '0, 1'b1, 1'b1);
      #3;
      reset = 1'b0;
      #1;
      check_reset_outputs("async");
      @(negedge clk);
      drive_idle();
      @(negedge clk);
      model_reset();
      reset = 1'b1;
      clear_logs();
      repeat (6) step(1'b0, '0, 1'b1, 1'b1);
      chk("post_rst_req", fire_log[0], RESET_PC);
      chk("post_rst_pc",  pop_log[0],  RESET_PC);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not complete, observed no finish expected finish");
      $fatal(1);
   end
endmodule
